// File: rtl/gray_timer_ctrl.sv
// Control sequencer for a Gray-code timer: latches the limit, restarts the timer and turns expiries into a sticky IRQ.
// Optional build macro GRAY_TIMER_CTRL_RELOAD_EN: in periodic mode, Limit_in is re-sampled on every re-arm.
module gray_timer_ctrl #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Periodic,
    input  logic [SIZE-1:0]  Limit_in,
    input  logic             Irq_Ack,
    input  logic             Tmr_Int,
    output logic             Tmr_Rst_n,
    output logic [SIZE-1:0]  Tmr_Limit,
    output logic             Busy,
    output logic             Irq,
    output logic             Overrun,
    output logic [CNT_W-1:0] Exp_Cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   mode;
    logic   start_acc;
    logic   expiry;
    logic   rearm;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment at the top keeps this combinational block free of inferred latches.
    always_comb begin
        state_nxt = state;
        if (Stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_acc) state_nxt = ARM;
                ARM:     state_nxt = RUN;
                RUN: begin
                    if (rearm)       state_nxt = ARM;
                    else if (expiry) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        Busy      = (state != IDLE);
        start_acc = (state == IDLE) && Start && !Stop;
        expiry    = (state == RUN) && Tmr_Int && !Stop;
        rearm     = expiry && mode;
    end

    // Timer restart line is a registered decode of the next state, so ARM always gives a full reset cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Tmr_Rst_n <= 1'b0;
        end else begin
            Tmr_Rst_n <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Tmr_Limit <= '0;
            mode      <= 1'b0;
        end else if (start_acc) begin
            Tmr_Limit <= Limit_in;
            mode      <= Periodic;
`ifdef GRAY_TIMER_CTRL_RELOAD_EN
        end else if (rearm) begin
            Tmr_Limit <= Limit_in;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Exp_Cnt <= '0;
        end else if (start_acc) begin
            Exp_Cnt <= '0;
        end else if (expiry && (Exp_Cnt != '1)) begin
            Exp_Cnt <= Exp_Cnt + 1'b1;
        end
    end

    // An expiry in the same cycle as an ack wins for Irq; Overrun is only set by an unacknowledged pending Irq.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Irq     <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            if (expiry)       Irq <= 1'b1;
            else if (Irq_Ack) Irq <= 1'b0;

            if (expiry && Irq && !Irq_Ack) Overrun <= 1'b1;
            else if (Irq_Ack)              Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_timer_ctrl.sv
// Self-checking bench for gray_timer_ctrl with a behavioural Gray-timer stand-in driving Tmr_Int.
// Expected reload spacing follows GRAY_TIMER_CTRL_RELOAD_EN.
module tb_gray_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, periodic, irq_ack;
    logic [7:0] limit_in;
    logic       tmr_int;
    logic       tmr_rst_n;
    logic [7:0] tmr_limit;
    logic       busy, irq, overrun;
    logic [7:0] exp_cnt;

    logic       start2, stop2;
    logic       tmr_int2;
    logic       tmr_rst_n2;
    logic [7:0] tmr_limit2;
    logic       busy2, irq2, overrun2;
    logic [1:0] exp_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_timer_ctrl #(.SIZE(8), .CNT_W(8)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Stop(stop), .Periodic(periodic),
        .Limit_in(limit_in), .Irq_Ack(irq_ack), .Tmr_Int(tmr_int),
        .Tmr_Rst_n(tmr_rst_n), .Tmr_Limit(tmr_limit), .Busy(busy),
        .Irq(irq), .Overrun(overrun), .Exp_Cnt(exp_cnt)
    );

    gray_timer_ctrl #(.SIZE(8), .CNT_W(2)) dut2 (
        .Clk(clk), .Rst(rst), .Start(start2), .Stop(stop2), .Periodic(1'b1),
        .Limit_in(8'd255), .Irq_Ack(1'b0), .Tmr_Int(tmr_int2),
        .Tmr_Rst_n(tmr_rst_n2), .Tmr_Limit(tmr_limit2), .Busy(busy2),
        .Irq(irq2), .Overrun(overrun2), .Exp_Cnt(exp_cnt2)
    );

    // Timer stand-in: counts while out of reset, raises a level Int one cycle after reaching the limit.
    logic [7:0] t_cnt, t_cnt2;
    always @(posedge clk or negedge tmr_rst_n) begin
        if (!tmr_rst_n) begin
            t_cnt   <= 8'd0;
            tmr_int <= 1'b0;
        end else if (t_cnt == tmr_limit) begin
            tmr_int <= 1'b1;
        end else begin
            t_cnt <= t_cnt + 8'd1;
        end
    end

    always @(posedge clk or negedge tmr_rst_n2) begin
        if (!tmr_rst_n2) begin
            t_cnt2   <= 8'd0;
            tmr_int2 <= 1'b0;
        end else if (t_cnt2 == tmr_limit2) begin
            tmr_int2 <= 1'b1;
        end else begin
            t_cnt2 <= t_cnt2 + 8'd1;
        end
    end

    typedef struct {
        logic       start;
        logic       stop;
        logic       periodic;
        logic [7:0] limit;
        logic       ack;
        logic       e_busy;
        logic       e_irq;
        logic       e_ovr;
        logic       e_rstn;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic p, input logic [7:0] l, input logic a, input logic k,
                       input logic b, input logic i, input logic o, input logic r, input logic [7:0] c);
        vec_t v;
        v.start = s; v.periodic = p; v.limit = l; v.ack = a; v.stop = k;
        v.e_busy = b; v.e_irq = i; v.e_ovr = o; v.e_rstn = r; v.e_cnt = c;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; periodic = 1'b0; irq_ack = 1'b0;
    endtask

    initial begin
        int  first_exp, second_exp, n_exp;
        logic [7:0] prev_cnt;
        bit  found;

        rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; irq_ack = 1'b0;
        limit_in = 8'd0; start2 = 1'b0; stop2 = 1'b0;

        // args: start, periodic, limit, ack, stop | busy, irq, ovr, rstn, cnt
        // One-shot L=5: Irq after edge 8, then ack.
        add(1, 0, 8'd5, 0, 0,  1, 0, 0, 0, 8'd0);
        for (int k = 1; k <= 7; k++) add(0, 0, 8'd5, 0, 0,  1, 0, 0, 1, 8'd0);
        add(0, 0, 8'd5, 0, 0,  0, 1, 0, 0, 8'd1);
        add(0, 0, 8'd5, 1, 0,  0, 0, 0, 0, 8'd1);
        // Periodic L=2: expiries at edges 5 and 10, overrun at 10, ack, stop.
        add(1, 1, 8'd2, 0, 0,  1, 0, 0, 0, 8'd0);
        for (int k = 1; k <= 4; k++) add(0, 0, 8'd2, 0, 0,  1, 0, 0, 1, 8'd0);
        add(0, 0, 8'd2, 0, 0,  1, 1, 0, 0, 8'd1);
        for (int k = 6; k <= 9; k++) add(0, 0, 8'd2, 0, 0,  1, 1, 0, 1, 8'd1);
        add(0, 0, 8'd2, 0, 0,  1, 1, 1, 0, 8'd2);
        add(0, 0, 8'd2, 1, 0,  1, 0, 0, 1, 8'd2);
        add(0, 0, 8'd2, 0, 1,  0, 0, 0, 0, 8'd2);
        // L=0 one-shot: Irq after edge 3.
        add(1, 0, 8'd0, 0, 0,  1, 0, 0, 0, 8'd0);
        add(0, 0, 8'd0, 0, 0,  1, 0, 0, 1, 8'd0);
        add(0, 0, 8'd0, 0, 0,  1, 0, 0, 1, 8'd0);
        add(0, 0, 8'd0, 0, 0,  0, 1, 0, 0, 8'd1);
        add(0, 0, 8'd0, 1, 0,  0, 0, 0, 0, 8'd1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, irq, overrun, tmr_rst_n, exp_cnt, tmr_limit},
              {1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        check("reset_outputs_cnt2", {busy2, irq2, overrun2, tmr_rst_n2, exp_cnt2}, 6'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].start; periodic = vecs[i].periodic; limit_in = vecs[i].limit;
            irq_ack = vecs[i].ack; stop = vecs[i].stop;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {busy, irq, overrun, tmr_rst_n, exp_cnt},
                  {vecs[i].e_busy, vecs[i].e_irq, vecs[i].e_ovr, vecs[i].e_rstn, vecs[i].e_cnt});
        end

        // Stop in the same cycle as Tmr_Int: expiry discarded.
        @(negedge clk);
        idle_inputs(); start = 1'b1; limit_in = 8'd3;
        @(posedge clk);
        #1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            idle_inputs();
            if (tmr_int) begin
                stop  = 1'b1;
                found = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("stop_int_seen", found, 1'b1);
        check("stop_vs_expiry", {busy, irq, overrun, tmr_rst_n, exp_cnt}, {4'b0000, 8'd0});

        // Start while busy ignored, then asynchronous reset mid-RUN.
        @(negedge clk);
        idle_inputs(); start = 1'b1; periodic = 1'b1; limit_in = 8'd2;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            idle_inputs();
            if (n == 3) begin
                start = 1'b1; periodic = 1'b0; limit_in = 8'd7;
            end
            @(posedge clk);
            #1;
            if (n == 3) check("start_busy_ignored", {busy, tmr_limit}, {1'b1, 8'd2});
        end
        check("periodic_kept", {busy, irq, tmr_rst_n, exp_cnt}, {3'b111, 8'd1});
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check("async_reset", {busy, irq, overrun, tmr_rst_n, exp_cnt, tmr_limit},
              {4'b0000, 8'd0, 8'd0});
        rst = 1'b0;

        // Saturating counter with CNT_W=2, periodic L=255 (expiries every 258 cycles).
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start2 = 1'b0;
        for (int n = 1; n <= 1300; n++) begin
            @(posedge clk);
            #1;
            if (n == 600)  check("sat_cnt_2",  exp_cnt2, 2'd2);
            if (n == 1035) check("sat_cnt_4",  exp_cnt2, 2'd3);
            if (n == 1300) check("sat_cnt_5",  exp_cnt2, 2'd3);
        end
        @(negedge clk);
        stop2 = 1'b1;
        @(posedge clk);
        #1;
        check("sat_stop", {busy2, exp_cnt2}, {1'b0, 2'd3});
        @(negedge clk);
        stop2 = 1'b0;

        // Period reload: L=4 then Limit_in=1 during the first period.
        idle_inputs(); start = 1'b1; periodic = 1'b1; limit_in = 8'd4;
        @(posedge clk);
        #1;
        first_exp = 0; second_exp = 0; n_exp = 0;
        prev_cnt = exp_cnt;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            idle_inputs();
            if (n == 3) limit_in = 8'd1;
            @(posedge clk);
            #1;
            if (exp_cnt != prev_cnt) begin
                n_exp++;
                if (n_exp == 1) first_exp = n;
                if (n_exp == 2) second_exp = n;
            end
            prev_cnt = exp_cnt;
        end
        check("reload_first_exp", first_exp, 7);
`ifdef GRAY_TIMER_CTRL_RELOAD_EN
        check("reload_second_exp", second_exp, 11);
`else
        check("reload_second_exp", second_exp, 14);
`endif
        @(negedge clk);
        idle_inputs(); stop = 1'b1;
        @(posedge clk);
        #1;
        check("final_stop", {busy, tmr_rst_n}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
